// File: rtl/mdio_phy_init_sequencer_if.sv
// AXI-Lite link between the PHY init sequencer and the MDIO master.
// 5-bit register address, 16-bit data; the Master modport issues requests.
interface axi_lite_interface;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [15:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport Master (
        output awaddr, awvalid, wdata, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport Slave (
        input  awaddr, awvalid, wdata, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mdio_phy_init_sequencer.sv
// DP83848 bring-up: soft reset, reset poll, AN config, then periodic
// BMSR/PHYSTS polling published to the MAC over an AXI-Lite master port.
// Ports: clk, reset (async active-low), axi_lite (Master), init_done,
// link_up, an_complete, speed_100, full_duplex, error, status_valid.
// Build option MDIO_INIT_FORCE_100FD_EN: force 100FD, AN off.
module mdio_phy_init_sequencer #(
    parameter int POWERUP_WAIT_CYCLES  = 125_000,
    parameter int POLL_INTERVAL_CYCLES = 12_500_000,
    parameter int TXN_TIMEOUT_CYCLES   = 1_250_000,
    parameter int RESET_POLL_MAX       = 16
) (
    input  logic              clk,
    input  logic              reset,
    axi_lite_interface.Master axi_lite,
    output logic              init_done,
    output logic              link_up,
    output logic              an_complete,
    output logic              speed_100,
    output logic              full_duplex,
    output logic              error,
    output logic              status_valid
);

    localparam logic [2:0] S_POWERUP   = 3'd0;
    localparam logic [2:0] S_WR_RST    = 3'd1;
    localparam logic [2:0] S_POLL_RST  = 3'd2;
    localparam logic [2:0] S_WR_CFG    = 3'd3;
    localparam logic [2:0] S_IDLE      = 3'd4;
    localparam logic [2:0] S_RD_BMSR   = 3'd5;
    localparam logic [2:0] S_RD_PHYSTS = 3'd6;
    localparam logic [2:0] S_ERROR     = 3'd7;

    localparam logic [1:0] P_ADDR = 2'd0;
    localparam logic [1:0] P_DATA = 2'd1;
    localparam logic [1:0] P_RESP = 2'd2;

    localparam int WAIT_MAX =
        (POWERUP_WAIT_CYCLES > POLL_INTERVAL_CYCLES) ?
        POWERUP_WAIT_CYCLES : POLL_INTERVAL_CYCLES;
    localparam int WW = $clog2(WAIT_MAX) + 1;
    localparam int TW = $clog2(TXN_TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RESET_POLL_MAX) + 1;

    localparam logic [WW-1:0] PWR_LAST  = WW'(POWERUP_WAIT_CYCLES - 1);
    localparam logic [WW-1:0] POLL_LAST = WW'(POLL_INTERVAL_CYCLES - 1);
    localparam logic [TW-1:0] TXN_LAST  = TW'(TXN_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RESET_POLL_MAX);

`ifdef MDIO_INIT_FORCE_100FD_EN
    localparam logic [15:0] CFG_WORD = 16'h2100;
    localparam logic        FORCE_AN = 1'b1;
`else
    localparam logic [15:0] CFG_WORD = 16'h1200;
    localparam logic        FORCE_AN = 1'b0;
`endif

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [2:0]    state;
    logic [1:0]    phase;
    logic [WW-1:0] wait_cnt;
    logic [TW-1:0] txn_cnt;
    logic [RW-1:0] retry_cnt;
    logic [RW-1:0] retry_nxt;
    logic          is_wr;
    logic          is_rd;
    logic          wr_done;
    logic          rd_done;
    logic          timeout;
    logic          unused_rdata;

    // Assert asynchronously, release two clocks after reset deasserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign is_wr = (state == S_WR_RST) || (state == S_WR_CFG);
    assign is_rd = (state == S_POLL_RST) || (state == S_RD_BMSR) ||
                   (state == S_RD_PHYSTS);

    // Handshake signals decode from registered state, so they are glitch
    // free and drop the cycle after their handshake.
    assign axi_lite.awvalid = is_wr && (phase == P_ADDR);
    assign axi_lite.wvalid  = is_wr && (phase == P_DATA);
    assign axi_lite.bready  = is_wr && (phase == P_RESP);
    assign axi_lite.arvalid = is_rd && (phase == P_ADDR);
    assign axi_lite.rready  = is_rd && (phase == P_RESP);
    assign axi_lite.awaddr  = 5'h00;
    assign axi_lite.wdata   = (state == S_WR_RST) ? 16'h8000 : CFG_WORD;
    assign axi_lite.araddr  = (state == S_RD_BMSR)   ? 5'h01 :
                              (state == S_RD_PHYSTS) ? 5'h10 : 5'h00;

    assign wr_done   = axi_lite.bready && axi_lite.bvalid;
    assign rd_done   = axi_lite.rready && axi_lite.rvalid;
    // A response landing on the last allowed cycle still wins.
    assign timeout   = (is_wr || is_rd) && (txn_cnt == TXN_LAST) &&
                       !wr_done && !rd_done;
    assign retry_nxt = retry_cnt + RW'(1);

    assign unused_rdata = ^axi_lite.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_POWERUP;
            phase        <= P_ADDR;
            wait_cnt     <= '0;
            txn_cnt      <= '0;
            retry_cnt    <= '0;
            init_done    <= 1'b0;
            link_up      <= 1'b0;
            an_complete  <= 1'b0;
            speed_100    <= 1'b0;
            full_duplex  <= 1'b0;
            error        <= 1'b0;
            status_valid <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            if (is_wr || is_rd) txn_cnt <= txn_cnt + TW'(1);
            if (timeout) begin
                state <= S_ERROR;
                error <= 1'b1;
            end else begin
                unique case (state)
                    S_POWERUP, S_IDLE: begin
                        if ((state == S_POWERUP && wait_cnt == PWR_LAST) ||
                            (state == S_IDLE && wait_cnt == POLL_LAST)) begin
                            state    <= (state == S_IDLE) ? S_RD_BMSR : S_WR_RST;
                            phase    <= P_ADDR;
                            txn_cnt  <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end
                    S_WR_RST, S_WR_CFG: begin
                        unique case (phase)
                            P_ADDR: if (axi_lite.awready) phase <= P_DATA;
                            P_DATA: if (axi_lite.wready) phase <= P_RESP;
                            default: if (wr_done) begin
                                phase   <= P_ADDR;
                                txn_cnt <= '0;
                                if (axi_lite.bresp != 2'b00) begin
                                    state <= S_ERROR;
                                    error <= 1'b1;
                                end else if (state == S_WR_RST) begin
                                    state <= S_POLL_RST;
                                end else begin
                                    init_done <= 1'b1;
                                    state     <= S_RD_BMSR;
                                end
                            end
                        endcase
                    end
                    S_POLL_RST, S_RD_BMSR, S_RD_PHYSTS: begin
                        if (phase == P_ADDR) begin
                            if (axi_lite.arready) phase <= P_RESP;
                        end else if (rd_done) begin
                            phase   <= P_ADDR;
                            txn_cnt <= '0;
                            if (axi_lite.rresp != 2'b00) begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end else if (state == S_POLL_RST) begin
                                if (!axi_lite.rdata[15]) begin
                                    state <= S_WR_CFG;
                                end else begin
                                    retry_cnt <= retry_nxt;
                                    if (retry_nxt == RETRY_MAX) begin
                                        state <= S_ERROR;
                                        error <= 1'b1;
                                    end
                                end
                            end else if (state == S_RD_BMSR) begin
                                link_up     <= axi_lite.rdata[2];
                                an_complete <= FORCE_AN | axi_lite.rdata[5];
                                state       <= S_RD_PHYSTS;
                            end else begin
                                speed_100    <= ~axi_lite.rdata[1];
                                full_duplex  <= axi_lite.rdata[2];
                                status_valid <= 1'b1;
                                state        <= S_IDLE;
                                wait_cnt     <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
